alu_iter: RTL and testbench
===========================

# alu_iter

Parametrised, registered RV32I/RV64I-style execute unit that extends the combinational base ALU with the M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). Base operations complete one cycle after acceptance; multiply and divide run on an iterative radix-2 datapath. The unit computes its own signed and unsigned compares and result flags. It sits in the execute stage behind a valid/ready handshake so that the pipeline stalls while an M operation is in flight.

## Interface
- XLEN, 32: operand and result width; a power of two, minimum 8.
- SHW, $clog2(XLEN): shift-amount width; derived, not overridden.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept an operation; high only in IDLE.
- a  in  XLEN  operand rs1.
- b  in  XLEN  operand rs2 or immediate.
- funct3  in  3  operation select (instruction funct3).
- control  in  1  instruction bit 30; selects SUB vs ADD and SRA vs SRL; ignored when mext=1.
- mext  in  1  instruction funct7[0]; selects an M-extension operation, with funct3 decoded as in RISC-V M.
- out_valid  out  1  result valid; held until it is consumed.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  registered result.
- zero  out  1  registered flag: result == 0.
- neg  out  1  registered flag: result[XLEN-1].

## Operation
- States: IDLE, MUL, DIV, DONE.
- Acceptance occurs when in_valid && in_ready at a rising edge. Operands and the decoded operation are latched at that edge.
- Base ops (mext=0), IDLE->DONE:
  - 000 add/sub
  - 001 sll
  - 010 slt
  - 011 sltu
  - 100 xor
  - 101 srl/sra
  - 110 or
  - 111 and
  - Shifts use b[SHW-1:0]; slt/sltu return zero-extended 1/0.
- MUL* (mext=1, funct3 0xx), IDLE->MUL:
  - Operands are converted to magnitudes according to signedness. MUL and MULHU treat both operands as unsigned, MULH treats both as signed, and MULHSU treats a as signed and b as unsigned.
  - Shift-add runs one bit per cycle for XLEN cycles into a 2*XLEN accumulator.
  - On completion the accumulator is negated if the sign of the product is negative.
  - MUL returns the low XLEN bits; the others return the high XLEN bits. Transition MUL->DONE.
- DIV/REM* (mext=1, funct3 1xx), IDLE->DIV:
  - Restoring division on magnitudes, one quotient bit per cycle, XLEN cycles, then DIV->DONE.
  - The quotient sign is sign(a) xor sign(b). The remainder takes the sign of a.
- Divide special cases take IDLE->DONE directly:
  - b==0: quotient all ones, remainder = a.
  - Signed overflow (a = most negative, b = -1): quotient = a, remainder = 0.
- DONE: out_valid=1, and result, zero and neg are stable. DONE->IDLE when out_ready=1.
- in_ready=0 in MUL, DIV and DONE. Input changes in those states are ignored.
- Reset puts the unit in IDLE with out_valid=0, result=0, zero=0, neg=0, and an internal counter/accumulator of 0.

## Timing
- Acceptance at edge E0:
  - Base op or divide special case: out_valid rises after E0+1.
  - MUL*/DIV* (normal): out_valid rises after E0+XLEN+1, which is 1 cycle to load, XLEN iterations and the final sign fix folded into the DONE load.
- out_valid stays high until the edge where out_ready=1. in_ready rises after that edge.
- Minimum issue interval is 2 cycles for base ops. There is no overlap of operations.
- Reset asserted mid-MUL/DIV aborts immediately and asynchronously. The partial result is discarded and never presented.
- The iteration counter is SHW+1 bits wide and does not wrap within an operation.

## Test plan
- Reset mid-DIV:
  - Stimulus: accept DIV, assert rst at iteration 10.
  - Required: out_valid=0, in_ready=1 after release, and no stale result appears.
- Base ops, XLEN=32:
  - a=0xFFFFFFF0, b=0x00000010.
  - add -> 0x00000000 with zero=1.
  - sub (control=1) -> 0xFFFFFFE0 with neg=1.
  - sra with b[4:0]=4 -> 0xFFFFFFFF.
  - slt -> 1.
  - sltu -> 0.
  - Each result arrives with out_valid 1 cycle after acceptance.
- Multiply, XLEN=32:
  - a=0xFFFFFFFF, b=2.
  - MUL -> 0xFFFFFFFE.
  - MULH -> 0xFFFFFFFF.
  - MULHU -> 0x00000001.
  - MULHSU -> 0xFFFFFFFF.
  - out_valid exactly 33 cycles after acceptance.
- Divide, XLEN=32:
  - DIV -7/2 -> 0xFFFFFFFD.
  - REM -7/2 -> 0xFFFFFFFF.
  - DIVU 7/0 -> 0xFFFFFFFF at latency 1.
  - DIV 0x80000000/-1 -> 0x80000000.
  - REM 0x80000000/-1 -> 0.
- Backpressure: hold out_ready=0 for 5 cycles after DONE.
  - Required: result, zero and neg are stable, in_ready=0, and new in_valid is ignored.
  - The next op is accepted only after out_ready=1.
- Parametric: XLEN=8 instance.
  - MUL 0x10*0x10 -> 0x00.
  - MULHU -> 0x01.
  - Shift uses b[2:0].
  - Latency is 9 cycles.

Source files
------------

// File: rtl/alu_iter.sv
// alu_iter: registered execute unit with an RV32I/RV64I-style base ALU plus
// the M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Base ops and divide special cases finish one cycle after acceptance.
// Multiply and divide run on a shared iterative radix-2 datapath that takes
// XLEN iterations.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  request handshake (in_ready high only when idle)
//   a, b               operands (rs1, rs2/imm)
//   funct3             operation select
//   control            instr[30]: SUB/SRA select for base ops
//   mext               funct7[0]: selects an M-extension operation
//   out_valid/out_ready result handshake (result held until consumed)
//   result, zero, neg  registered result and flags
module alu_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      funct3,
   input  logic            control,
   input  logic            mext,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            neg
);

   localparam int SHW   = $clog2(XLEN);
   // One spare bit so the counter can reach XLEN without wrapping.
   localparam int CNT_W = SHW + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   // Multiply: {high partial sum, remaining multiplier bits}.
   // Divide:   {partial remainder, dividend bits becoming quotient bits}.
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opb;      // multiplicand or divisor magnitude
   logic              is_div;
   logic              sel_hi;   // mul: return high half; div: return remainder
   logic              neg_fix;  // negate the final magnitude

   logic              accept;
   logic [SHW-1:0]    shamt;
   logic [XLEN-1:0]   base_res;
   logic              sgn_a, sgn_b, a_neg, b_neg;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              div_zero, div_ovf;
   logic [XLEN-1:0]   spec_res;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next, mul_fix;
   logic [XLEN:0]     div_shift, div_diff;
   logic              div_ge;
   logic [2*XLEN-1:0] div_next;
   logic [XLEN-1:0]   div_part;
   logic [XLEN-1:0]   final_res;
   logic              last_iter;

   logic              res_load;
   logic [XLEN-1:0]   res_d;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign accept    = in_valid && in_ready;
   assign shamt     = b[SHW-1:0];
   assign last_iter = (cnt == CNT_W'(XLEN - 1));

   // Base ALU.
   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      base_res = '0;
      case (funct3)
         3'b000: base_res = control ? (a - b) : (a + b);
         3'b001: base_res = a << shamt;
         3'b010: base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         3'b011: base_res = {{(XLEN-1){1'b0}}, (a < b)};
         3'b100: base_res = a ^ b;
         3'b101: begin
            // Kept as separate branches: a ?: would force the signed shift unsigned.
            if (control) base_res = $signed(a) >>> shamt;
            else         base_res = a >> shamt;
         end
         3'b110: base_res = a | b;
         default: base_res = a & b;
      endcase
   end

   // Operand signedness: MULH s/s, MULHSU s/u, MUL/MULHU u/u; DIV/REM signed.
   always_comb begin
      sgn_a = 1'b0;
      sgn_b = 1'b0;
      if (funct3[2]) begin
         sgn_a = ~funct3[0];
         sgn_b = ~funct3[0];
      end else begin
         sgn_a = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
         sgn_b = (funct3[1:0] == 2'b01);
      end
   end

   assign a_neg = sgn_a & a[XLEN-1];
   assign b_neg = sgn_b & b[XLEN-1];
   // The most negative value maps to 2^(XLEN-1), which still fits unsigned.
   assign mag_a = a_neg ? -a : a;
   assign mag_b = b_neg ? -b : b;

   assign div_zero = (b == '0);
   assign div_ovf  = ~funct3[0] && (a == MOST_NEG) && (b == '1);

   always_comb begin
      spec_res = '0;
      if (div_zero) spec_res = funct3[1] ? a : '1;
      else          spec_res = funct3[1] ? '0 : a;
   end

   // One shift-add step: add the multiplicand into the high half when the
   // current multiplier bit is set, then shift the whole accumulator right.
   assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + ({1'b0, opb} & {(XLEN+1){acc[0]}});
   assign mul_next = {mul_sum, acc[XLEN-1:1]};

   // One restoring-division step. The shifted remainder is below 2*divisor,
   // so XLEN+1 bits hold both it and the signed difference.
   assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
   assign div_diff  = div_shift - {1'b0, opb};
   assign div_ge    = ~div_diff[XLEN];
   assign div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                       acc[XLEN-2:0], div_ge};

   // Sign fix folded into the final iteration so DONE loads the true result.
   assign mul_fix  = neg_fix ? -mul_next : mul_next;
   assign div_part = sel_hi ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];

   always_comb begin
      final_res = '0;
      if (is_div)      final_res = neg_fix ? -div_part : div_part;
      else if (sel_hi) final_res = mul_fix[2*XLEN-1:XLEN];
      else             final_res = mul_fix[XLEN-1:0];
   end

   // Result register load enable and data, shared by all completion paths.
   always_comb begin
      res_load = 1'b0;
      res_d    = '0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (!mext) begin
                  res_load = 1'b1;
                  res_d    = base_res;
               end else if (funct3[2] && (div_zero || div_ovf)) begin
                  res_load = 1'b1;
                  res_d    = spec_res;
               end
            end
         end
         S_MUL, S_DIV: begin
            if (last_iter) begin
               res_load = 1'b1;
               res_d    = final_res;
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         acc     <= '0;
         opb     <= '0;
         is_div  <= 1'b0;
         sel_hi  <= 1'b0;
         neg_fix <= 1'b0;
         result  <= '0;
         zero    <= 1'b0;
         neg     <= 1'b0;
      end else begin
         if (res_load) begin
            result <= res_d;
            zero   <= (res_d == '0);
            neg    <= res_d[XLEN-1];
         end
         case (state)
            S_IDLE: begin
               if (accept) begin
                  cnt <= '0;
                  if (!mext) begin
                     state <= S_DONE;
                  end else if (!funct3[2]) begin
                     state   <= S_MUL;
                     acc     <= {{XLEN{1'b0}}, mag_b};
                     opb     <= mag_a;
                     is_div  <= 1'b0;
                     sel_hi  <= (funct3[1:0] != 2'b00);
                     neg_fix <= a_neg ^ b_neg;
                  end else if (div_zero || div_ovf) begin
                     state <= S_DONE;
                  end else begin
                     state   <= S_DIV;
                     acc     <= {{XLEN{1'b0}}, mag_a};
                     opb     <= mag_b;
                     is_div  <= 1'b1;
                     sel_hi  <= funct3[1];
                     neg_fix <= funct3[1] ? a_neg : (a_neg ^ b_neg);
                  end
               end
            end
            S_MUL, S_DIV: begin
               acc <= is_div ? div_next : mul_next;
               cnt <= cnt + 1'b1;
               if (last_iter) state <= S_DONE;
            end
            default: begin
               if (out_ready) state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: a table of directed vectors with
// hand-computed results applied to an XLEN=32 and an XLEN=8 instance, plus
// hand-written backpressure and reset-during-divide sequences.
module tb_alu_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a, b;
   logic [2:0]  funct3;
   logic        control, mext, out_ready;
   logic        iv32, iv8;

   logic        ir32, ov32, z32, n32;
   logic [31:0] res32;
   logic        ir8, ov8, z8, n8;
   logic [7:0]  res8;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_iter #(.XLEN(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
      .a(a), .b(b), .funct3(funct3), .control(control), .mext(mext),
      .out_valid(ov32), .out_ready(out_ready),
      .result(res32), .zero(z32), .neg(n32)
   );

   alu_iter #(.XLEN(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
      .a(a[7:0]), .b(b[7:0]), .funct3(funct3), .control(control), .mext(mext),
      .out_valid(ov8), .out_ready(out_ready),
      .result(res8), .zero(z8), .neg(n8)
   );

   typedef struct {
      string       name;
      bit          w8;
      bit          mx;
      bit [2:0]    f3;
      bit          ctl;
      bit [31:0]   va, vb, exp;
      bit          ez, en;
      int          lat;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input string nm, input bit w8, input bit mx, input bit [2:0] f3,
                      input bit ctl, input bit [31:0] va, input bit [31:0] vb,
                      input bit [31:0] exp, input bit ez, input bit en, input int lat);
      vec_t v;
      v.name = nm; v.w8 = w8; v.mx = mx; v.f3 = f3; v.ctl = ctl;
      v.va = va; v.vb = vb; v.exp = exp; v.ez = ez; v.en = en; v.lat = lat;
      vq.push_back(v);
   endtask

   // Issue one op, measure edges from acceptance (inclusive) to out_valid,
   // compare result/flags/latency, then consume it.
   task automatic run(input vec_t v);
      int lat;
      logic ov;
      @(negedge clk);
      a = v.va; b = v.vb; funct3 = v.f3; control = v.ctl; mext = v.mx;
      if (v.w8) iv8 = 1'b1; else iv32 = 1'b1;
      @(posedge clk);
      #1;
      iv8 = 1'b0; iv32 = 1'b0;
      lat = 1;
      ov = v.w8 ? ov8 : ov32;
      while (!ov && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         ov = v.w8 ? ov8 : ov32;
      end
      check({v.name, " latency"}, lat, v.lat);
      check({v.name, " result"}, v.w8 ? {24'h0, res8} : res32, v.exp);
      check({v.name, " zero"}, v.w8 ? z8 : z32, {31'h0, v.ez});
      check({v.name, " neg"}, v.w8 ? n8 : n32, {31'h0, v.en});
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({v.name, " in_ready after consume"}, v.w8 ? ir8 : ir32, 32'h1);
   endtask

   initial begin
      int stale;
      rst = 1'b1; a = '0; b = '0; funct3 = '0; control = 1'b0; mext = 1'b0;
      out_ready = 1'b0; iv32 = 1'b0; iv8 = 1'b0;

      //   name            w8 mx f3      ctl a             b             exp           z  n  lat
      add("add",          0, 0, 3'b000, 0, 32'hFFFFFFF0, 32'h00000010, 32'h00000000, 1, 0, 1);
      add("sub",          0, 0, 3'b000, 1, 32'hFFFFFFF0, 32'h00000010, 32'hFFFFFFE0, 0, 1, 1);
      add("add_wrap",     0, 0, 3'b000, 0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 1);
      add("sll_mask",     0, 0, 3'b001, 0, 32'hFFFFFFF0, 32'h00000024, 32'hFFFFFF00, 0, 1, 1);
      add("slt",          0, 0, 3'b010, 0, 32'hFFFFFFF0, 32'h00000010, 32'h00000001, 0, 0, 1);
      add("sltu",         0, 0, 3'b011, 0, 32'hFFFFFFF0, 32'h00000010, 32'h00000000, 1, 0, 1);
      add("xor",          0, 0, 3'b100, 0, 32'hFFFFFFF0, 32'h00000010, 32'hFFFFFFE0, 0, 1, 1);
      add("srl",          0, 0, 3'b101, 0, 32'hFFFFFFF0, 32'h00000004, 32'h0FFFFFFF, 0, 0, 1);
      add("sra",          0, 0, 3'b101, 1, 32'hFFFFFFF0, 32'h00000004, 32'hFFFFFFFF, 0, 1, 1);
      add("or",           0, 0, 3'b110, 0, 32'hFFFFFFF0, 32'h00000010, 32'hFFFFFFF0, 0, 1, 1);
      add("and",          0, 0, 3'b111, 0, 32'hFFFFFFF0, 32'h00000010, 32'h00000010, 0, 0, 1);
      add("mul",          0, 1, 3'b000, 0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 0, 1, 33);
      add("mulh",         0, 1, 3'b001, 0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 0, 1, 33);
      add("mulhsu",       0, 1, 3'b010, 0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 0, 1, 33);
      add("mulhu",        0, 1, 3'b011, 0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 0, 0, 33);
      add("mulhu_max",    0, 1, 3'b011, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 1, 33);
      add("mulh_m1m1",    0, 1, 3'b001, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 0, 33);
      add("mulh_min",     0, 1, 3'b001, 0, 32'h80000000, 32'h80000000, 32'h40000000, 0, 0, 33);
      add("mul_ctl_ign",  0, 1, 3'b000, 1, 32'h12345678, 32'h00000010, 32'h23456780, 0, 0, 33);
      add("div_m7_2",     0, 1, 3'b100, 0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 0, 1, 33);
      add("rem_m7_2",     0, 1, 3'b110, 0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 0, 1, 33);
      add("div_7_m2",     0, 1, 3'b100, 0, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 0, 1, 33);
      add("rem_7_m2",     0, 1, 3'b110, 0, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 0, 0, 33);
      add("divu_100_7",   0, 1, 3'b101, 0, 32'h00000064, 32'h00000007, 32'h0000000E, 0, 0, 33);
      add("remu_100_7",   0, 1, 3'b111, 0, 32'h00000064, 32'h00000007, 32'h00000002, 0, 0, 33);
      add("divu_3_5",     0, 1, 3'b101, 0, 32'h00000003, 32'h00000005, 32'h00000000, 1, 0, 33);
      add("divu_max_1",   0, 1, 3'b101, 0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 0, 1, 33);
      add("div_min_2",    0, 1, 3'b100, 0, 32'h80000000, 32'h00000002, 32'hC0000000, 0, 1, 33);
      add("divu_by0",     0, 1, 3'b101, 0, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 0, 1, 1);
      add("remu_by0",     0, 1, 3'b111, 0, 32'h00000007, 32'h00000000, 32'h00000007, 0, 0, 1);
      add("div_by0",      0, 1, 3'b100, 0, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 0, 1, 1);
      add("div_ovf",      0, 1, 3'b100, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1, 1);
      add("rem_ovf",      0, 1, 3'b110, 0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0, 1);
      add("x8_mul",       1, 1, 3'b000, 0, 32'h00000010, 32'h00000010, 32'h00000000, 1, 0, 9);
      add("x8_mulhu",     1, 1, 3'b011, 0, 32'h00000010, 32'h00000010, 32'h00000001, 0, 0, 9);
      add("x8_mulh_min",  1, 1, 3'b001, 0, 32'h00000080, 32'h00000080, 32'h00000040, 0, 0, 9);
      add("x8_sll",       1, 0, 3'b001, 0, 32'h00000001, 32'h0000000B, 32'h00000008, 0, 0, 1);
      add("x8_sra",       1, 0, 3'b101, 1, 32'h00000080, 32'h000000F9, 32'h000000C0, 0, 1, 1);
      add("x8_div",       1, 1, 3'b100, 0, 32'h000000F9, 32'h00000002, 32'h000000FD, 0, 1, 9);
      add("x8_div_ovf",   1, 1, 3'b100, 0, 32'h00000080, 32'h000000FF, 32'h00000080, 0, 1, 1);

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", {31'h0, ov32}, 32'h0);
      check("reset in_ready", {31'h0, ir32}, 32'h1);
      check("reset result", res32, 32'h0);
      check("reset zero", {31'h0, z32}, 32'h0);
      check("reset neg", {31'h0, n32}, 32'h0);
      check("reset x8 out_valid", {31'h0, ov8}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vq[i]) run(vq[i]);

      // Backpressure: ADD 5+3 is held while out_ready=0; a SUB 100-1 offered
      // meanwhile must not be taken until the held result is consumed.
      @(negedge clk);
      a = 32'd5; b = 32'd3; funct3 = 3'b000; control = 1'b0; mext = 1'b0; iv32 = 1'b1;
      @(posedge clk);
      #1;
      iv32 = 1'b0;
      check("bp out_valid", {31'h0, ov32}, 32'h1);
      @(negedge clk);
      a = 32'd100; b = 32'd1; control = 1'b1; iv32 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp hold result %0d", i), res32, 32'h8);
         check($sformatf("bp hold flags %0d", i), {30'h0, z32, n32}, 32'h0);
         check($sformatf("bp hold in_ready %0d", i), {31'h0, ir32}, 32'h0);
         check($sformatf("bp hold out_valid %0d", i), {31'h0, ov32}, 32'h1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp released out_valid", {31'h0, ov32}, 32'h0);
      check("bp released in_ready", {31'h0, ir32}, 32'h1);
      @(negedge clk);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      iv32 = 1'b0;
      check("bp next out_valid", {31'h0, ov32}, 32'h1);
      check("bp next result", res32, 32'd99);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;

      // Reset mid-divide: DIVU 100/7, reset asynchronously during iteration 10.
      @(negedge clk);
      a = 32'd100; b = 32'd7; funct3 = 3'b101; control = 1'b0; mext = 1'b1; iv32 = 1'b1;
      @(posedge clk);
      #1;
      iv32 = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("rst mid-div out_valid", {31'h0, ov32}, 32'h0);
      check("rst mid-div in_ready", {31'h0, ir32}, 32'h1);
      @(negedge clk);
      rst = 1'b0;
      stale = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (ov32) stale++;
      end
      check("rst mid-div stale out_valid cycles", stale, 32'h0);
      check("rst mid-div result cleared", res32, 32'h0);
      check("rst mid-div in_ready after", {31'h0, ir32}, 32'h1);
      run(vq[23]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
